// File: rtl/mac_pipe.sv
// Pipelined dot-product MAC: operands are registered, multiplied, then accumulated; the result is valid 3 cycles after the last pair.
// in_ready drops once VEC_LEN pairs are taken, and out_valid/y are held until the consumer asserts out_ready.
module mac_pipe #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 4,
  parameter int SIGNED  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  y,
  output logic              sat,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(VEC_LEN + 1);
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic              s1_vld;
  logic              s2_vld;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W:0]    acc_x;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf;
  logic              accept;
  logic              go;

  assign accept = in_valid && in_ready;
  assign go     = start && (state == IDLE || (state == DONE && out_ready));

  // Operands are extended to full product width so the low PROD_W bits are the exact product.
  generate
    if (SIGNED != 0) begin : g_signed
      assign prod_c = {{DATA_W{s1_a[DATA_W-1]}}, s1_a} * {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
      assign prod_x = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
      assign acc_x  = {acc[ACC_W-1], acc};
    end else begin : g_unsigned
      assign prod_c = {{DATA_W{1'b0}}, s1_a} * {{DATA_W{1'b0}}, s1_b};
      assign prod_x = {{(ACC_W+1-PROD_W){1'b0}}, prod};
      assign acc_x  = {1'b0, acc};
    end
  endgenerate

  assign sum = acc_x + prod_x;

  always_comb begin
    ovf     = 1'b0;
    acc_nxt = sum[ACC_W-1:0];
    if (SIGNED != 0) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        ovf     = 1'b1;
        acc_nxt = sum[ACC_W] ? S_MIN : S_MAX;
      end
    end else if (sum[ACC_W]) begin
      ovf     = 1'b1;
      acc_nxt = U_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      prod   <= '0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      if (accept) begin
        s1_a <= a;
        s1_b <= b;
      end
      if (s1_vld) prod <= prod_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (s2_vld) begin
        acc <= acc_nxt;
        if (ovf) sat <= 1'b1;
      end
      case (state)
        RUN: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(VEC_LEN - 1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_vld && !s2_vld) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= acc;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
      // A new vector starts from IDLE, or straight out of DONE when the result is taken on the same edge.
      if (go) begin
        state    <= RUN;
        cnt      <= '0;
        acc      <= '0;
        sat      <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: four configurations share one stimulus stream; a scoreboard checks each result.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  ir, ov, bz, st;
  logic [19:0] y0, y1;
  logic [15:0] y2, y3;

  always #5 clk = ~clk;

  mac_pipe #(.DATA_W(8), .ACC_W(20), .VEC_LEN(4), .SIGNED(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .y(y0), .sat(st[0]), .busy(bz[0]));
  mac_pipe #(.DATA_W(8), .ACC_W(20), .VEC_LEN(4), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .y(y1), .sat(st[1]), .busy(bz[1]));
  mac_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(4), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .y(y2), .sat(st[2]), .busy(bz[2]));
  mac_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(4), .SIGNED(1)) u3 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .out_valid(ov[3]), .out_ready(out_ready), .y(y3), .sat(st[3]), .busy(bz[3]));

  typedef struct {
    logic [19:0] y0;
    logic [19:0] y1;
    logic [15:0] y2;
    logic [15:0] y3;
    logic [3:0]  s;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] va[4];
  logic [7:0] vb[4];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         n_pop = 0;
  logic       acc_flag = 1'b0;
  logic       prev_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference dot product with per-step clamping; wide arithmetic so nothing wraps.
  function automatic logic [31:0] model(input bit sgn, input int accw, output logic s);
    longint acc, p, hi, lo;
    acc = 0;
    s   = 1'b0;
    hi  = sgn ? (64'sd1 <<< (accw - 1)) - 1 : (64'sd1 <<< accw) - 1;
    lo  = sgn ? -(64'sd1 <<< (accw - 1)) : 0;
    for (int i = 0; i < 4; i++) begin
      p = sgn ? longint'($signed(va[i])) * longint'($signed(vb[i]))
              : longint'(va[i]) * longint'(vb[i]);
      acc = acc + p;
      if (acc > hi) begin acc = hi; s = 1'b1; end
      if (acc < lo) begin acc = lo; s = 1'b1; end
    end
    return 32'(acc) & ((32'd1 << accw) - 32'd1);
  endfunction

  task automatic push_exp();
    exp_t e;
    logic s;
    e.y0 = 20'(model(1'b1, 20, s)); e.s[0] = s;
    e.y1 = 20'(model(1'b0, 20, s)); e.s[1] = s;
    e.y2 = 16'(model(1'b0, 16, s)); e.s[2] = s;
    e.y3 = 16'(model(1'b1, 16, s)); e.s[3] = s;
    sb.push_back(e);
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc_flag = in_valid && ir[0];
    if (acc_flag) last_acc = cyc + 1;
    if (ov[0] && !prev_ov) chk("latency", 32'(cyc), 32'(last_acc + 3));
    prev_ov = ov[0];
    if (ov[0] && out_ready) begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
      chk("ov_agree", 32'(ov), 32'hf);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("y_s20", 32'(y0), 32'(e.y0));
        chk("y_u20", 32'(y1), 32'(e.y1));
        chk("y_u16", 32'(y2), 32'(e.y2));
        chk("y_s16", 32'(y3), 32'(e.y3));
        chk("sat", 32'(st), 32'(e.s));
      end
      n_pop++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_vec(input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int a3, input int b3);
    va[0] = 8'(a0); vb[0] = 8'(b0);
    va[1] = 8'(a1); vb[1] = 8'(b1);
    va[2] = 8'(a2); vb[2] = 8'(b2);
    va[3] = 8'(a3); vb[3] = 8'(b3);
  endtask

  task automatic feed_pair(input int i);
    int t;
    a = va[i];
    b = vb[i];
    in_valid = 1'b1;
    t = 0;
    do begin
      step();
      start = 1'b0;
      t++;
    end while (!acc_flag && t < 16);
    chk("accepted", 32'(acc_flag), 32'd1);
    in_valid = 1'b0;
  endtask

  // gap: idle cycles after each pair; poke: stray start pulses in RUN and DRAIN.
  task automatic run_vec(input int gap, input bit poke, input bit do_start);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    push_exp();
    chk("run_busy", 32'(bz), 32'hf);
    chk("run_in_ready", 32'(ir), 32'hf);
    chk("run_sat_clear", 32'(st), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (poke && i == 2) start = 1'b1;
      feed_pair(i);
      repeat (gap) step();
    end
    if (poke) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic wait_result();
    int n0, t;
    n0 = n_pop;
    t  = 0;
    while (n_pop == n0 && t < 60) begin
      step();
      t++;
    end
    chk("result_seen", 32'(n_pop - n0), 32'd1);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ctrl", {16'h0, ir, ov, bz, st}, 32'h0);
    chk("rst_y0", 32'(y0), 32'h0);
    chk("rst_y3", 32'(y3), 32'h0);

    // Basic signed dot product: 12 - 10 - 7 + 100.
    set_vec(3, 4, -2, 5, 7, -1, 10, 10);
    run_vec(0, 1'b0, 1'b1);
    wait_result();
    chk("t1_y95", 32'(y0), 32'd95);
    step();
    chk("t1_ov_one_cycle", 32'(ov), 32'h0);
    chk("t1_idle_busy", 32'(bz), 32'h0);

    // Unsigned full-scale: fits in 20 bits, clamps in 16.
    set_vec(255, 255, 255, 255, 255, 255, 255, 255);
    run_vec(0, 1'b0, 1'b1);
    wait_result();
    chk("t2_u20", 32'(y1), 32'd260100);
    chk("t2_u16", 32'(y2), 32'd65535);
    chk("t2_u16_sat", 32'(st[2]), 32'd1);

    // Signed negative clamp, then a clean vector clears sat.
    set_vec(-128, 127, -128, 127, -128, 127, -128, 127);
    run_vec(0, 1'b0, 1'b1);
    wait_result();
    chk("t3_s16_min", 32'(y3), 32'h8000);
    chk("t3_s16_sat", 32'(st[3]), 32'd1);
    set_vec(1, 1, 1, 1, 1, 1, 1, 1);
    run_vec(0, 1'b0, 1'b1);
    wait_result();
    chk("t3_s16_y4", 32'(y3), 32'd4);
    chk("t3_s16_nosat", 32'(st[3]), 32'd0);

    // Gapped input, consumer stalls in DONE, stray start ignored, then start+out_ready restarts.
    set_vec(-5, 9, 17, 3, 100, -100, 2, 2);
    out_ready = 1'b0;
    run_vec(1, 1'b0, 1'b1);
    t = 0;
    while (!ov[0] && t < 40) begin
      step();
      t++;
    end
    chk("t4_ov_seen", 32'(ov[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      step();
      start = 1'b0;
      chk("t4_hold_ov", 32'(ov), 32'hf);
      chk("t4_hold_y", 32'(y0), 32'(sb[0].y0));
      chk("t4_done_in_ready", 32'(ir), 32'h0);
    end
    set_vec(6, 7, -8, 9, 10, 11, -12, -13);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_vec(0, 1'b0, 1'b0);
    wait_result();

    // Reset mid-vector abandons it; the next vector is unaffected.
    set_vec(50, 50, 60, 60, 70, 70, 80, 80);
    start = 1'b1;
    step();
    start = 1'b0;
    feed_pair(0);
    feed_pair(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_ctrl", {16'h0, ir, ov, bz, st}, 32'h0);
    chk("t5_rst_y0", 32'(y0), 32'h0);
    set_vec(1, 2, 1, 2, 1, 2, 1, 2);
    run_vec(0, 1'b0, 1'b1);
    wait_result();
    chk("t5_y8", 32'(y0), 32'd8);

    // Stray start pulses in RUN and DRAIN must not disturb the result.
    set_vec(-7, -7, 12, -3, 33, 4, -1, 90);
    run_vec(0, 1'b1, 1'b1);
    wait_result();
    step();
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate engine and the successor to the 4-bit single-shot MAC.
- Computes a dot product of VEC_LEN operand pairs, streamed in over a valid/ready handshake. Supports configurable width, signed or unsigned mode, and saturating accumulation.
- Returns the result over a valid/ready output handshake with a sticky saturation flag.
- Sits between an operand source (FIFO/controller) and a result consumer in the MAC datapath.

Parameters:
- DATA_W, 8: operand width of a and b.
- ACC_W, 20: accumulator and result width; must be >= 2*DATA_W.
- VEC_LEN, 4: pairs per dot product; must be >= 1.
- SIGNED, 1: 1 means two's-complement operands and accumulator; 0 means unsigned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new dot product.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept a pair.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- y  out  ACC_W  accumulated result.
- sat  out  1  saturation occurred during this dot product (sticky).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst high at a rising edge): state=IDLE; in_ready=0, out_valid=0, y=0, sat=0, busy=0. All pipeline valids, count and accumulator cleared. Reset mid-operation abandons the vector with no output.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Clears acc, sat and count in that edge.
  - RUN: in_ready=1 while count<VEC_LEN. A pair is accepted at an edge with in_valid&&in_ready, and count increments. The edge accepting pair VEC_LEN moves to DRAIN, with in_ready=0 from then on.
  - DRAIN: waits until the pipeline is empty (both stage valids 0), then -> DONE. At that edge out_valid=1 and y=acc.
  - DONE: out_valid and y held stable. out_valid&&out_ready -> IDLE (out_valid=0).
- start handling:
  - start in DONE together with out_ready=1: the result is handed over and the FSM goes directly to RUN (acc/sat/count cleared).
  - start in RUN, DRAIN, or in DONE without out_ready is ignored.
- Pipeline for a pair accepted at edge k:
  - Stage 1 registers a, b at edge k.
  - Stage 2 registers the full-precision product (2*DATA_W bits, signed or unsigned per SIGNED) at k+1.
  - The accumulator adds the sign- or zero-extended product at k+2.
- Latency and throughput:
  - Last pair accepted at edge k gives out_valid high from edge k+3.
  - Throughput is 1 pair/cycle, with in_valid gaps allowed at any time.
- Saturation:
  - Sum computed in ACC_W+1 bits.
  - If SIGNED=1, overflow clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1). If SIGNED=0, overflow clamps to 2^ACC_W-1.
  - Any clamp sets sat, which stays 1 until the next start.
  - Accumulation continues from the clamped value.
- y changes only when entering DONE. Between results it holds the last result; it is 0 after reset.
- busy=1 in RUN/DRAIN/DONE.
- VEC_LEN=1: a single pair goes RUN->DRAIN on its accept edge.

Test Plan:
- Default params, SIGNED=1, start, then pairs (3,4),(−2,5),(7,−1),(10,10) back-to-back with out_ready=1 -> out_valid 3 cycles after the last accept, y=95, sat=0, single-cycle out_valid.
- SIGNED=0, DATA_W=8, pairs (255,255)x4 -> y=260100, sat=0. Repeat with ACC_W=16 -> y=65535, sat=1.
- SIGNED=1, ACC_W=16, pairs (−128,127)x4 -> y=−32768, sat=1. The next start clears sat, and pairs (1,1)x4 -> y=4, sat=0.
- in_valid toggled every other cycle, out_ready low for 5 cycles after out_valid -> y and out_valid held stable, in_ready=0 throughout DONE, next start ignored until handshake. start+out_ready in DONE -> RUN directly, new vector correct.
- rst asserted after 2 of 4 pairs accepted -> next cycle all outputs 0, state IDLE. A following full vector of (1,2)x4 -> y=8, with no contamination from the aborted vector.
- start pulsed during RUN and during DRAIN -> no effect on count or acc; the result matches the undisturbed reference.
